status_flag_unit: RTL and testbench

- Parametrised successor to the CPU status register.
- Holds NFLAGS architectural flags and accepts per-bit masked software writes in four modes: load, xor (XSTAT), set and clear.
- Accepts masked ALU flag updates, with sticky bits that the ALU can only set.
- Provides a DEPTH-entry shadow stack for flag save/restore, plus a trap state machine that automatically saves the flags and enters trap mode when an enabled flag asserts.
- Sits between the ALU/decode stage and the CPU control sequencer.

---
 rtl/status_flag_unit.sv | 143 ++++++++++++++
 tb/tb_status_flag_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_flag_unit.sv
// Status flag register with masked software/ALU updates, a shadow save/restore
// stack and a trap state machine that auto-saves the flags on an enabled flag.
module status_flag_unit #(
    parameter int                NFLAGS      = 13,
    parameter int                DEPTH       = 4,
    parameter int                TRAP_BIT    = 12,
    parameter logic [NFLAGS-1:0] STICKY_MASK = 13'h0080
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [1:0]                   wr_op_i,
    input  logic [NFLAGS-1:0]            wr_data_i,
    input  logic [NFLAGS-1:0]            wr_mask_i,
    input  logic                         alu_upd_i,
    input  logic [NFLAGS-1:0]            alu_flags_i,
    input  logic [NFLAGS-1:0]            alu_mask_i,
    input  logic [NFLAGS-1:0]            trap_mask_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         err_clr_i,
    output logic [NFLAGS-1:0]            flags_o,
    output logic                         trap_req_o,
    output logic                         in_trap_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         stk_full_o,
    output logic                         stk_empty_o,
    output logic                         stk_err_o
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [NFLAGS-1:0] TRAP_ONEHOT = NFLAGS'(1) << TRAP_BIT;

    typedef enum logic {IDLE = 1'b0, IN_TRAP = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [NFLAGS-1:0]   flags_q, flags_d;
    logic [NFLAGS-1:0]   alu_val, sw_val, sw_bits;
    logic [DW-1:0]       depth_q, depth_d;
    logic                trap_req_q;
    logic                stk_err_q, stk_err_d;
    logic [NFLAGS-1:0]   stack_q [DEPTH];
    logic [PW-1:0]       wr_idx, top_idx;
    logic                trap_entry, stk_full, stk_empty;
    logic                do_push, do_pop, stk_fault;

    assign stk_full  = (depth_q == DW'(DEPTH));
    assign stk_empty = (depth_q == '0);
    assign wr_idx    = PW'(depth_q);
    assign top_idx   = PW'(depth_q - DW'(1));

    // Stack arbitration: a trap entry takes the stack port and masks external push/pop.
    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        stk_fault = 1'b0;
        if (trap_entry) begin
            do_push   = !stk_full;
            stk_fault = stk_full;
        end else if (push_i && !pop_i) begin
            do_push   = !stk_full;
            stk_fault = stk_full;
        end else if (pop_i && !push_i) begin
            do_pop    = !stk_empty;
            stk_fault = stk_empty;
        end
    end

    always_comb begin
        alu_val = flags_q;
        if (alu_upd_i) begin
            alu_val = (flags_q & ~alu_mask_i)
                    | (alu_mask_i & (alu_flags_i | (flags_q & STICKY_MASK)));
        end
        sw_bits = wr_data_i & wr_mask_i;
        sw_val  = alu_val;
        if (wr_en_i) begin
            case (wr_op_i)
                2'b00:   sw_val = (alu_val & ~wr_mask_i) | sw_bits;
                2'b01:   sw_val = alu_val ^ sw_bits;
                2'b10:   sw_val = alu_val | sw_bits;
                default: sw_val = alu_val & ~sw_bits;
            endcase
        end
        flags_d = do_pop ? stack_q[top_idx] : sw_val;
        if (trap_entry) begin
            flags_d = flags_d | TRAP_ONEHOT;
        end
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end
        stk_err_d = stk_fault | (stk_err_q & ~err_clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            flags_q    <= '0;
            depth_q    <= '0;
            trap_req_q <= 1'b0;
            stk_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            depth_q    <= depth_d;
            trap_req_q <= trap_entry;
            stk_err_q  <= stk_err_d;
        end
    end

    // Stack storage has no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_q[wr_idx] <= flags_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trap_entry) state_d = IN_TRAP;
            IN_TRAP: if (!flags_q[TRAP_BIT]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trap_entry = (state_q == IDLE)
                   && (|(flags_q & trap_mask_i & ~TRAP_ONEHOT))
                   && !flags_q[TRAP_BIT];
        in_trap_o  = (state_q == IN_TRAP);
    end

    assign flags_o     = flags_q;
    assign trap_req_o  = trap_req_q;
    assign depth_o     = depth_q;
    assign stk_full_o  = stk_full;
    assign stk_empty_o = stk_empty;
    assign stk_err_o   = stk_err_q;
endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed vector table, hand-written trap/reset
// sequences and a randomized run against a queue-based reference model.
module tb_status_flag_unit;
    localparam int                DEPTH  = 4;
    localparam logic [12:0]       STICKY = 13'h0080;
    localparam logic [12:0]       ALL    = 13'h1FFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, alu_upd = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [1:0]  wr_op = 2'b00;
    logic [12:0] wr_data = '0, wr_mask = '0, alu_flags = '0, alu_mask = '0, trap_mask = '0;
    logic [12:0] flags;
    logic        trap_req, in_trap, stk_full, stk_empty, stk_err;
    logic [2:0]  depth;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: the stack is a queue whose size is the depth.
    logic [12:0] m_flags;
    logic [12:0] m_stack[$];
    bit          m_in_trap, m_trap_req, m_err;

    status_flag_unit dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_en), .wr_op_i(wr_op), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
        .alu_upd_i(alu_upd), .alu_flags_i(alu_flags), .alu_mask_i(alu_mask),
        .trap_mask_i(trap_mask), .push_i(push), .pop_i(pop), .err_clr_i(err_clr),
        .flags_o(flags), .trap_req_o(trap_req), .in_trap_o(in_trap), .depth_o(depth),
        .stk_full_o(stk_full), .stk_empty_o(stk_empty), .stk_err_o(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic [12:0] wd, wm;
        logic        au;
        logic [12:0] af, am;
        logic        ps, pp, ec;
        logic [12:0] e_flags;
        int          e_depth;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] op, logic [12:0] wd, logic [12:0] wm,
                                logic au, logic [12:0] af, logic [12:0] am,
                                logic ps, logic pp, logic ec,
                                logic [12:0] e_flags, int e_depth, logic e_err);
        vec_t v;
        v.we = we; v.op = op; v.wd = wd; v.wm = wm; v.au = au; v.af = af; v.am = am;
        v.ps = ps; v.pp = pp; v.ec = ec; v.e_flags = e_flags; v.e_depth = e_depth; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(logic we, logic [1:0] op, logic [12:0] wd, logic [12:0] wm,
                         logic au, logic [12:0] af, logic [12:0] am,
                         logic ps, logic pp, logic ec);
        wr_en = we; wr_op = op; wr_data = wd; wr_mask = wm;
        alu_upd = au; alu_flags = af; alu_mask = am;
        push = ps; pop = pp; err_clr = ec;
    endtask

    task automatic idle();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_flags = '0; m_stack.delete(); m_in_trap = 0; m_trap_req = 0; m_err = 0;
    endtask

    // Next state straight from the behavioural rules, evaluated on the old state.
    task automatic model_step();
        logic [12:0] nf;
        bit trig, fault, do_pop;
        trig   = !m_in_trap && ((m_flags & trap_mask & ~13'h1000) != 0) && !m_flags[12];
        fault  = 0;
        do_pop = 0;
        if (trig || (push && !pop)) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else fault = 1;
        end else if (pop && !push) begin
            if (m_stack.size() > 0) do_pop = 1;
            else fault = 1;
        end
        nf = m_flags;
        if (do_pop) begin
            nf = m_stack.pop_back();
        end else begin
            if (alu_upd)
                for (int i = 0; i < 13; i++)
                    if (alu_mask[i]) nf[i] = STICKY[i] ? (nf[i] | alu_flags[i]) : alu_flags[i];
            if (wr_en)
                for (int i = 0; i < 13; i++)
                    if (wr_mask[i])
                        case (wr_op)
                            2'b00: nf[i] = wr_data[i];
                            2'b01: nf[i] = nf[i] ^ wr_data[i];
                            2'b10: nf[i] = nf[i] | wr_data[i];
                            default: nf[i] = nf[i] & ~wr_data[i];
                        endcase
        end
        if (trig) nf[12] = 1'b1;
        if (err_clr) m_err = 0;
        if (fault) m_err = 1;
        if (trig) m_in_trap = 1;
        else if (m_in_trap && !m_flags[12]) m_in_trap = 0;
        m_trap_req = trig;
        m_flags = nf;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
    endtask

    vec_t vt[$];

    initial begin
        // masked modes, sticky ALU, overlapping writes, stack fill/drain, error flag
        vt.push_back(mk(1, 2'b00, 13'h00F, 13'h00F, 0, 0, 0, 0, 0, 0, 13'h00F, 0, 0));
        vt.push_back(mk(1, 2'b01, 13'h005, ALL,     0, 0, 0, 0, 0, 0, 13'h00A, 0, 0));
        vt.push_back(mk(1, 2'b10, 13'h100, ALL,     0, 0, 0, 0, 0, 0, 13'h10A, 0, 0));
        vt.push_back(mk(1, 2'b11, 13'h001, ALL,     0, 0, 0, 0, 0, 0, 13'h10A, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 1, 13'h080, 13'h080, 0, 0, 0, 13'h18A, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 1, 13'h000, 13'h080, 0, 0, 0, 13'h18A, 0, 0));
        vt.push_back(mk(1, 2'b11, 13'h080, 13'h080, 0, 0, 0, 0, 0, 0, 13'h10A, 0, 0));
        vt.push_back(mk(1, 2'b00, 13'h000, ALL,     0, 0, 0, 0, 0, 0, 13'h000, 0, 0));
        vt.push_back(mk(1, 2'b00, 13'h000, 13'h001, 1, 13'h003, 13'h003, 0, 0, 0, 13'h002, 0, 0));
        vt.push_back(mk(1, 2'b00, 13'h011, ALL, 0, 0, 0, 1, 0, 0, 13'h011, 1, 0));
        vt.push_back(mk(1, 2'b00, 13'h022, ALL, 0, 0, 0, 1, 0, 0, 13'h022, 2, 0));
        vt.push_back(mk(1, 2'b00, 13'h033, ALL, 0, 0, 0, 1, 0, 0, 13'h033, 3, 0));
        vt.push_back(mk(1, 2'b00, 13'h044, ALL, 0, 0, 0, 1, 0, 0, 13'h044, 4, 0));
        vt.push_back(mk(1, 2'b00, 13'h055, ALL, 0, 0, 0, 1, 0, 0, 13'h055, 4, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 13'h033, 3, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 13'h022, 2, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 13'h011, 1, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 13'h002, 0, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 13'h002, 0, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 13'h002, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 13'h002, 0, 1));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 13'h002, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 13'h002, 0, 0));
        vt.push_back(mk(1, 2'b00, 13'h000, ALL, 0, 0, 0, 1, 0, 0, 13'h000, 1, 0));
        vt.push_back(mk(1, 2'b00, 13'h1FF, ALL, 1, 13'h0FF, ALL, 0, 1, 0, 13'h002, 0, 0));

        do_reset();
        check("reset_flags", flags, 0);
        check("reset_depth", depth, 0);
        check("reset_empty", stk_empty, 1);
        check("reset_full", stk_full, 0);
        check("reset_err", stk_err, 0);
        check("reset_trap_req", trap_req, 0);
        check("reset_in_trap", in_trap, 0);

        foreach (vt[i]) begin
            drive(vt[i].we, vt[i].op, vt[i].wd, vt[i].wm, vt[i].au, vt[i].af, vt[i].am,
                  vt[i].ps, vt[i].pp, vt[i].ec);
            tick();
            $display("vec %0d: flags=%h depth=%0d err=%0d", i, flags, depth, stk_err);
            check($sformatf("vec%0d_flags", i), flags, vt[i].e_flags);
            check($sformatf("vec%0d_depth", i), depth, vt[i].e_depth);
            check($sformatf("vec%0d_full", i), stk_full, vt[i].e_depth == DEPTH);
            check($sformatf("vec%0d_empty", i), stk_empty, vt[i].e_depth == 0);
            check($sformatf("vec%0d_err", i), stk_err, vt[i].e_err);
        end

        // hardware trap: entry latency, auto-save, pop exit, re-entry
        do_reset();
        trap_mask = 13'h080;
        drive(0, 2'b00, 0, 0, 1, 13'h080, 13'h080, 0, 0, 0);
        tick(); idle();
        $display("trap c1: flags=%h trap_req=%0d in_trap=%0d", flags, trap_req, in_trap);
        check("trap_c1_flags", flags, 13'h080);
        check("trap_c1_req", trap_req, 0);
        tick();
        $display("trap c2: flags=%h trap_req=%0d in_trap=%0d depth=%0d", flags, trap_req, in_trap, depth);
        check("trap_c2_flags", flags, 13'h1080);
        check("trap_c2_req", trap_req, 1);
        check("trap_c2_in_trap", in_trap, 1);
        check("trap_c2_depth", depth, 1);
        tick();
        $display("trap c3: trap_req=%0d in_trap=%0d", trap_req, in_trap);
        check("trap_c3_req", trap_req, 0);
        check("trap_c3_in_trap", in_trap, 1);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(); idle();
        $display("trap pop: flags=%h depth=%0d in_trap=%0d", flags, depth, in_trap);
        check("trap_pop_flags", flags, 13'h080);
        check("trap_pop_depth", depth, 0);
        check("trap_pop_in_trap", in_trap, 1);
        tick();
        $display("trap exit: in_trap=%0d trap_req=%0d", in_trap, trap_req);
        check("trap_exit_in_trap", in_trap, 0);
        check("trap_exit_req", trap_req, 0);
        tick();
        $display("trap reentry: flags=%h trap_req=%0d depth=%0d", flags, trap_req, depth);
        check("trap_reentry_req", trap_req, 1);
        check("trap_reentry_flags", flags, 13'h1080);
        check("trap_reentry_depth", depth, 1);

        // software clear of TRAP exits; software set of TRAP is a software trap
        drive(1, 2'b11, 13'h1080, ALL, 0, 0, 0, 0, 0, 0);
        tick(); idle();
        tick();
        $display("sw exit: flags=%h in_trap=%0d", flags, in_trap);
        check("sw_exit_in_trap", in_trap, 0);
        drive(1, 2'b10, 13'h1080, ALL, 0, 0, 0, 0, 0, 0);
        tick(); idle();
        tick();
        $display("sw trap: flags=%h trap_req=%0d in_trap=%0d depth=%0d", flags, trap_req, in_trap, depth);
        check("sw_trap_req", trap_req, 0);
        check("sw_trap_in_trap", in_trap, 0);
        check("sw_trap_depth", depth, 1);

        // asynchronous reset inside the trap entry cycle
        do_reset();
        trap_mask = 13'h080;
        drive(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0, 1, 13'h080, 13'h080, 0, 0, 0);
        tick(); idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        $display("async rst: flags=%h trap_req=%0d in_trap=%0d depth=%0d", flags, trap_req, in_trap, depth);
        check("arst_flags", flags, 0);
        check("arst_trap_req", trap_req, 0);
        check("arst_in_trap", in_trap, 0);
        check("arst_depth", depth, 0);
        tick();
        check("arst_hold_req", trap_req, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized run against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            trap_mask = ($urandom_range(0, 3) == 0) ? 13'h0 : 13'($urandom) & 13'h0C81;
            drive($urandom_range(0, 9) < 4, 2'($urandom), 13'($urandom), 13'($urandom),
                  $urandom_range(0, 9) < 4, 13'($urandom), 13'($urandom),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            tick();
            $display("rnd %0d: flags=%h depth=%0d trap_req=%0d in_trap=%0d err=%0d",
                     n, flags, depth, trap_req, in_trap, stk_err);
            check("rnd_flags", flags, m_flags);
            check("rnd_depth", depth, m_stack.size());
            check("rnd_full", stk_full, m_stack.size() == DEPTH);
            check("rnd_empty", stk_empty, m_stack.size() == 0);
            check("rnd_trap_req", trap_req, m_trap_req);
            check("rnd_in_trap", in_trap, m_in_trap);
            check("rnd_err", stk_err, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
